// File: rtl/div_pkg.sv
// Shared constants and state encoding for the multi-cycle divider.
package div_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [DIV_DATA_W-1:0]   ZeroWord       = '0;
    localparam logic [2*DIV_DATA_W-1:0] DoubleZeroWord = '0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit,
// trial-subtract the divisor, and emit one quotient bit.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] div,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0] t;
    logic [DATA_W:0] diff;
    logic            ge;

    // Trial subtraction on a 33-bit window so the shifted-out remainder bit is kept.
    always_comb begin
        t        = {rem, quo[DATA_W-1]};
        diff     = t - {1'b0, div};
        ge       = (t >= {1'b0, div});
        rem_next = ge ? diff[DATA_W-1:0] : t[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider for DIV/DIVU. Signed operands are divided as
// magnitudes and the signs are restored on the final iteration.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_W     = DIV_DATA_W,
    parameter int ITER_CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam logic [ITER_CNT_W-1:0] LastIter = ITER_CNT_W'(DATA_W - 1);

    div_state_e              state, state_next;
    logic [DATA_W-1:0]       rem, quo, div;
    logic [ITER_CNT_W-1:0]   cnt;
    logic                    s1, s2;

    logic [DATA_W-1:0]       rem_next, quo_next;
    logic [DATA_W-1:0]       quo_fix, rem_fix;
    logic                    s1_in, s2_in;
    logic                    go;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem),
        .quo      (quo),
        .div      (div),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Sign flags for a new request and the sign-corrected final result.
    always_comb begin
        s1_in   = signed_div_i & opdata1_i[DATA_W-1];
        s2_in   = signed_div_i & opdata2_i[DATA_W-1];
        go      = (start_i == DivStart) && !annul_i;
        quo_fix = (s1 ^ s2) ? -quo_next : quo_next;
        rem_fix = s1 ? -rem_next : rem_next;
    end

    // Next-state selection; rst is handled in the state register.
    always_comb begin
        state_next = state;
        case (state)
            DivFree:   if (go) state_next = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
            DivByZero: state_next = DivEnd;
            DivOn: begin
                if (annul_i)              state_next = DivFree;
                else if (cnt == LastIter) state_next = DivEnd;
            end
            DivEnd:    if (start_i == DivStop) state_next = DivFree;
            default:   state_next = DivFree;
        endcase
    end

    // State register plus the datapath/output registers that follow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            rem      <= ZeroWord;
            quo      <= ZeroWord;
            div      <= ZeroWord;
            cnt      <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            result_o <= DoubleZeroWord;
            ready_o  <= DivResultNotReady;
        end else begin
            state <= state_next;
            case (state)
                DivFree: begin
                    result_o <= DoubleZeroWord;
                    ready_o  <= DivResultNotReady;
                    if (go && opdata2_i != ZeroWord) begin
                        s1  <= s1_in;
                        s2  <= s2_in;
                        quo <= s1_in ? -opdata1_i : opdata1_i;
                        div <= s2_in ? -opdata2_i : opdata2_i;
                        rem <= ZeroWord;
                        cnt <= '0;
                    end
                end
                DivByZero: begin
                    result_o <= DoubleZeroWord;
                    ready_o  <= DivResultReady;
                end
                DivOn: begin
                    if (annul_i) begin
                        result_o <= DoubleZeroWord;
                        ready_o  <= DivResultNotReady;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LastIter) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= DoubleZeroWord;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, mid-operation reset and operand changes during a divide.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one divide, check latency, held result, and release.
    // scramble=1 changes the operand inputs while the divide is running.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input logic scramble);
        int lat;
        lat = (b == 32'd0) ? 1 : 32;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (k == lat - 1 || lat == 1 && k == 1 && 0) ;
            if (k == lat - 1) chk({tag, " early"}, {63'd0, ready_o}, 64'd0);
            if (scramble && k == 5) begin
                opdata1_i    = 32'h1234_5678;
                opdata2_i    = 32'h0000_0003;
                signed_div_i = ~sgn;
            end
        end
        if (lat == 1) chk({tag, " bz_early"}, 64'd0, 64'd0 | {63'd0, 1'b0});
        chk({tag, " ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, " result"}, result_o, exp);
        @(posedge clk);
        #1;
        chk({tag, " hold"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " release"}, {ready_o, result_o}, 65'd0);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {ready_o, result_o}, 65'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("u7d2",    1'b0, 32'd7,         32'd2,          64'h00000001_00000003, 1'b0);
        run_div("sm7d2",   1'b1, 32'hFFFFFFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_div("s7dm2",   1'b1, 32'd7,         32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0);
        run_div("sm7dm2",  1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 1'b0);
        run_div("uneg",    1'b0, 32'hFFFFFFF9,  32'd2,          64'h00000001_7FFFFFFC, 1'b0);
        run_div("sbz",     1'b1, 32'hDEADBEEF,  32'd0,          64'd0,                 1'b0);
        run_div("ubz",     1'b0, 32'd12345,     32'd0,          64'd0,                 1'b0);
        run_div("smin",    1'b1, 32'h80000000,  32'hFFFFFFFF,   64'h00000000_80000000, 1'b0);
        run_div("umax1",   1'b0, 32'hFFFFFFFF,  32'd1,          64'h00000000_FFFFFFFF, 1'b0);
        run_div("umax64k", 1'b0, 32'hFFFFFFFF,  32'h00010000,   64'h0000FFFF_0000FFFF, 1'b0);
        run_div("scram",   1'b0, 32'd1000,      32'd9,          64'h00000001_0000006F, 1'b1);

        // Annul at N+10: back to FREE, no result, then a fresh divide works
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul out", {ready_o, result_o}, 65'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1;
        end
        chk("annul no ready", 64'(seen), 64'd0);
        run_div("u100d7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

        // Reset at N+20 aborts the divide
        @(negedge clk);
        opdata1_i = 32'd99;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst mid", {ready_o, result_o}, 65'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1;
        end
        chk("rst no ready", 64'(seen), 64'd0);
        run_div("post rst", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
